// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory stage: word type, memory-stage FSM
// encoding and the number of byte-offset bits ignored by LL/SC matching.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int WBYTE_OFF = 2;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memstate_t;

endpackage

// File: rtl/ll_link_reg.sv
// Per-core LL/SC link register. It holds the word-aligned linked address and
// a valid bit, and compares another address against the link.
module ll_link_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int BYTE_OFF = WBYTE_OFF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              set_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic              snoop_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  input  logic [WORD_W-1:0] cmp_addr_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] addr_o,
  output logic              match_o
);

  localparam logic [WORD_W-1:0] TAG_MASK =
    ~((WORD_W'(1) << BYTE_OFF) - WORD_W'(1));

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] link_q, link_d;
  logic              snoop_cur;
  logic              snoop_new;

  function automatic logic same_word(input logic [WORD_W-1:0] a,
                                     input logic [WORD_W-1:0] b);
    logic [WORD_W-1:0] diff;
    diff = a ^ b;
    return (diff >> BYTE_OFF) == '0;
  endfunction

  always_comb begin
    snoop_cur = snoop_i & valid_q & same_word(snoop_addr_i, link_q);
    snoop_new = snoop_i & same_word(snoop_addr_i, set_addr_i);
    valid_d   = valid_q;
    link_d    = link_q;
    // A snoop to the address being linked this very cycle leaves the link dead.
    if (set_i) begin
      valid_d = ~snoop_new;
      link_d  = set_addr_i & TAG_MASK;
    end else if (clr_i || snoop_cur) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      link_q  <= '0;
    end else begin
      valid_q <= valid_d;
      link_q  <= link_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = link_q;
  assign match_o = valid_q & same_word(cmp_addr_i, link_q);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage controller: issues one outstanding data-cache request,
// freezes the pipeline until dhit, and returns load data or the SC result.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int BYTE_OFF = WBYTE_OFF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              ll_i,
  input  logic              sc_i,
  input  logic              halt_i,
  input  logic              flush,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] store_data_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dmem_load_o,
  output logic              freeze_o,
  output logic              halt_o,
  output logic              link_valid_o,
  output logic [WORD_W-1:0] link_addr_o
);

  memstate_t         state_q, state_d;
  logic              dren_q, dren_d;
  logic              dwen_q, dwen_d;
  logic              ll_q, ll_d;
  logic              sc_q, sc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] load_q, load_d;
  logic              halt_q, halt_d;

  logic              valid_op;
  logic              sc_fail;
  logic              link_match;
  logic              link_set;
  logic              link_clr;
  logic [WORD_W-1:0] link_cmp_addr;

  always_comb begin
    valid_op = (mem_read_i | mem_write_i) & ~flush & ~halt_q;
    sc_fail  = valid_op & mem_write_i & ~mem_read_i & sc_i & ~link_match;

    state_d = state_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    ll_d    = ll_q;
    sc_d    = sc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    load_d  = load_q;
    halt_d  = halt_q;

    case (state_q)
      IDLE: begin
        if (valid_op) begin
          if (sc_fail) begin
            load_d = '0;
          end else begin
            state_d = BUSY;
            dren_d  = mem_read_i;
            dwen_d  = mem_write_i & ~mem_read_i;
            ll_d    = mem_read_i & ll_i;
            sc_d    = mem_write_i & ~mem_read_i & sc_i;
            addr_d  = addr_i;
            data_d  = store_data_i;
          end
        end else if (halt_i) begin
          halt_d = 1'b1;
        end
      end
      BUSY: begin
        if (dhit) begin
          state_d = DONE;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          if (dren_q) begin
            load_d = dload;
          end else if (sc_q) begin
            load_d = WORD_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The link is compared against the incoming SC address while idle and
  // against the in-flight store address while busy.
  always_comb begin
    link_cmp_addr = (state_q == BUSY) ? addr_q : addr_i;
    link_set = (state_q == BUSY) & dhit & dren_q & ll_q;
    link_clr = ((state_q == IDLE) & sc_fail) |
               ((state_q == BUSY) & dhit & dwen_q & (sc_q | link_match));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      ll_q    <= ll_d;
      sc_q    <= sc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
      halt_q  <= halt_d;
    end
  end

  ll_link_reg #(
    .WORD_W   (WORD_W),
    .BYTE_OFF (BYTE_OFF)
  ) u_link (
    .clk          (CLK),
    .nrst         (nRST),
    .set_i        (link_set),
    .set_addr_i   (addr_q),
    .clr_i        (link_clr),
    .snoop_i      (snoop_inv),
    .snoop_addr_i (snoop_addr),
    .cmp_addr_i   (link_cmp_addr),
    .valid_o      (link_valid_o),
    .addr_o       (link_addr_o),
    .match_o      (link_match)
  );

  // Freeze covers the issuing idle cycle too, so EX/MEM holds the op.
  assign freeze_o = nRST & (((state_q == IDLE) & valid_op & ~sc_fail) |
                            (state_q == BUSY));

  assign dREN        = dren_q;
  assign dWEN        = dwen_q;
  assign daddr       = addr_q;
  assign dstore      = data_q;
  assign dmem_load_o = load_q;
  assign halt_o      = halt_q;

endmodule
